count_history_display: RTL and testbench
========================================

// Module: count_history_display
// PURPOSE
//  Downstream consumer of the 3-bit mod-7 counter value. Logs each distinct value the
//  counter takes into a DEPTH-entry history; most recent entry is entry 0.
//  Time-multiplexes the history onto a DEPTH-digit common-anode 7-segment display.
//  Also keeps a saturating count of value changes and a sticky flag for the illegal value 7.
// PARAMETERS
//  DEPTH          4   history entries = display digits (2..8)
//  PRESCALE_BITS  17  scan prescaler width; digit advances every 2**PRESCALE_BITS clocks (bench uses 2)
// PORTS
//  clock          in   1        system clock, rising-edge
//  reset          in   1        asynchronous, active-high; clears all state immediately
//  value          in   3        counter value, synchronous to clock
//  segments       out  7        {g,f,e,d,c,b,a}, active-low
//  digitselect    out  DEPTH    one-hot active-low digit enable
//  change_count   out  8        number of logged changes, saturates at 255
//  error          out  1        sticky: value==7 has been sampled since reset
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain. Reset is asynchronous and active-high.
//  - Reset state: primed=0, all history valid bits=0, scan index=0, prescaler=0,
//    change_count=0, error=0.
//  - Resulting outputs in reset: digitselect={DEPTH-1{1},0}, segments=7'b1111111 (blank).
//  History capture
//  - First rising edge after reset release: hist[0]<=value, valid[0]<=1, primed<=1.
//    change_count is not incremented on this edge.
//  - Later edges: if value != hist[0], shift:
//    - hist[i]<=hist[i-1] and valid[i]<=valid[i-1];
//    - hist[0]<=value, valid[0]<=1;
//    - change_count<=change_count+1, holding at 255.
//  - If value == hist[0], nothing changes.
//  - Latency: a new value is visible in the history and change_count one clock after the
//    edge that samples it. The oldest entry is discarded on a shift.
//  - error<=1 on any edge that samples value==7. Cleared only by reset.
//  - Value 7 is logged like any other value.
//  Display scan
//  - The PRESCALE_BITS-bit prescaler increments every clock.
//  - On the edge where the prescaler wraps from all-ones to 0, the scan index advances
//    by one. It wraps from DEPTH-1 to 0.
//  - digitselect = ~(1<<scan), combinational from registers.
//  - segments = decode(hist[scan]) when valid[scan]; blank when not valid.
//  - decode table: 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001
//    5:0010010  6:0000010  7:0111111 (dash).
//  - Scanning runs independently of history updates. Simultaneous shift and scan advance
//    is legal: the new digit shows the post-shift entry.
//  - Reset mid-scan or mid-update: outputs return to reset values without waiting for a
//    clock edge.
// TESTING (DEPTH=4, PRESCALE_BITS=2, 2ns clock)
//  1 Reset asserted, no clock
//    -> digitselect=1110, segments=1111111, change_count=0, error=0.
//  2 Release reset; drive value=3 for 2 clocks, then value=5 for 1 clock
//    -> hist[0]=5, hist[1]=3, valid=0011, change_count=1.
//    -> digit 0 shows 0010010; digits 2-3 blank.
//  3 Hold value steady for 16 clocks
//    -> digitselect steps 1110, 1101, 1011, 0111, 1110; each step lasts exactly 4 clocks.
//  4 Feed a live mod-7 counter sequence 0,1,...,6,0,1 (one change per clock)
//    -> hist={1,0,6,5} (entry 0 first), change_count=8, error=0.
//  5 Drive value=7 for 1 clock, then value=2
//    -> error=1 and stays 1; the digit holding 7 shows 0111111.
//  6a Toggle value 1/2 for 300 clocks
//    -> change_count stops at 255.
//  6b Then pulse reset between clock edges
//    -> all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/count_history_display_if.sv
// count_history_display_if: counter value in, multiplexed display and status out
`timescale 1ns/100ps
interface count_history_display_if #(
    parameter int DEPTH = 4
);
    logic [2:0]       value;
    logic [6:0]       segments;
    logic [DEPTH-1:0] digitselect;
    logic [7:0]       change_count;
    logic             error;

    modport master (
        output value,
        input  segments, digitselect, change_count, error
    );

    modport slave (
        input  value,
        output segments, digitselect, change_count, error
    );
endinterface

// File: rtl/count_history_display.sv
// count_history_display: logs distinct mod-7 counter values and scans them onto a 7-segment display
`timescale 1ns/100ps
module count_history_display #(
    parameter int DEPTH         = 4,
    parameter int PRESCALE_BITS = 17
) (
    input logic clock,
    input logic reset,
    count_history_display_if.slave bus
);
    localparam int SW = $clog2(DEPTH);

    logic                     primed;
    logic [2:0]               hist [DEPTH];
    logic [DEPTH-1:0]         valid;
    logic [SW-1:0]            scan;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [7:0]               change_count;
    logic                     error;
    logic                     shift;

    function automatic logic [6:0] decode(input logic [2:0] d);
        case (d)
            3'd0:    return 7'b1000000;
            3'd1:    return 7'b1111001;
            3'd2:    return 7'b0100100;
            3'd3:    return 7'b0110000;
            3'd4:    return 7'b0011001;
            3'd5:    return 7'b0010010;
            3'd6:    return 7'b0000010;
            default: return 7'b0111111;
        endcase
    endfunction

    assign shift = primed && (bus.value != hist[0]);

    // first edge after reset seeds entry 0; afterwards each new value shifts the history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            primed       <= 1'b0;
            valid        <= '0;
            change_count <= 8'd0;
            error        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= 3'd0;
        end else begin
            if (!primed) begin
                primed   <= 1'b1;
                hist[0]  <= bus.value;
                valid[0] <= 1'b1;
            end else if (shift) begin
                for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
                hist[0]      <= bus.value;
                valid        <= {valid[DEPTH-2:0], 1'b1};
                change_count <= (change_count == 8'hff) ? change_count : change_count + 8'd1;
            end
            if (bus.value == 3'd7) error <= 1'b1;
        end
    end

    // free-running prescaler; the scanned digit advances when it wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            scan     <= '0;
        end else begin
            prescale <= prescale + 1'b1;
            if (&prescale) scan <= (scan == SW'(DEPTH - 1)) ? '0 : scan + 1'b1;
        end
    end

    assign bus.digitselect  = ~(DEPTH'(1) << scan);
    assign bus.segments     = valid[scan] ? decode(hist[scan]) : 7'b1111111;
    assign bus.change_count = change_count;
    assign bus.error        = error;
endmodule

// File: tb/tb_count_history_display.sv
// tb_count_history_display: table, directed and random checks against a queue-based model
`timescale 1ns/100ps
module tb_count_history_display;
    localparam int DEPTH = 4;
    localparam int PSC   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    count_history_display_if #(.DEPTH(DEPTH)) bus ();
    count_history_display #(.DEPTH(DEPTH), .PRESCALE_BITS(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #1 clock = ~clock;

    logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b0111111};

    int hq[$];
    bit m_primed;
    bit m_err;
    int m_cnt;
    int m_n;

    typedef struct {
        bit         rst_first;
        logic [2:0] v;
        logic [7:0] cnt;
        logic       err;
        logic [6:0] seg;
    } vec_t;
    vec_t tab [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hq.delete();
        m_primed = 0;
        m_err = 0;
        m_cnt = 0;
        m_n = 0;
    endfunction

    function automatic void model_step(input int v);
        if (!m_primed) begin
            hq.push_front(v);
            m_primed = 1;
        end else if (v != hq[0]) begin
            hq.push_front(v);
            if (hq.size() > DEPTH) void'(hq.pop_back());
            if (m_cnt < 255) m_cnt++;
        end
        if (v == 7) m_err = 1;
        m_n++;
    endfunction

    function automatic int exp_scan();
        return (m_n / PSC) % DEPTH;
    endfunction

    function automatic logic [6:0] exp_seg();
        int s = exp_scan();
        return (s < hq.size()) ? seg_tab[hq[s]] : 7'b1111111;
    endfunction

    task automatic cmp_model();
        logic [DEPTH-1:0] eds = ~(DEPTH'(1) << exp_scan());
        chk("model_ds", 32'(bus.digitselect), 32'(eds));
        chk("model_seg", 32'(bus.segments), 32'(exp_seg()));
        chk("model_cnt", 32'(bus.change_count), 32'(m_cnt));
        chk("model_err", 32'(bus.error), 32'(m_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ds"}, 32'(bus.digitselect), 32'(4'b1110));
        chk({tag, "_seg"}, 32'(bus.segments), 32'(7'b1111111));
        chk({tag, "_cnt"}, 32'(bus.change_count), 0);
        chk({tag, "_err"}, 32'(bus.error), 0);
    endtask

    task automatic tick(input logic [2:0] v);
        bus.value = v;
        @(posedge clock);
        model_step(int'(v));
        @(negedge clock);
        cmp_model();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        #0.3;
        check_reset_outputs("rst_pulse");
        #0.3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_vec(input int i);
        if (tab[i].rst_first) pulse_reset();
        tick(tab[i].v);
        chk("vec_cnt", 32'(bus.change_count), 32'(tab[i].cnt));
        chk("vec_err", 32'(bus.error), 32'(tab[i].err));
        chk("vec_seg", 32'(bus.segments), 32'(tab[i].seg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h4[4] = '{1, 0, 6, 5};
        logic [2:0] last;
        tab[0]  = '{0, 3'd3, 8'd0, 1'b0, 7'b0110000};
        tab[1]  = '{0, 3'd3, 8'd0, 1'b0, 7'b0110000};
        tab[2]  = '{0, 3'd5, 8'd1, 1'b0, 7'b0010010};
        tab[3]  = '{1, 3'd0, 8'd0, 1'b0, 7'b1000000};
        tab[4]  = '{0, 3'd1, 8'd1, 1'b0, 7'b1111001};
        tab[5]  = '{0, 3'd2, 8'd2, 1'b0, 7'b0100100};
        tab[6]  = '{0, 3'd3, 8'd3, 1'b0, 7'b0100100};
        tab[7]  = '{0, 3'd4, 8'd4, 1'b0, 7'b0110000};
        tab[8]  = '{0, 3'd5, 8'd5, 1'b0, 7'b0011001};
        tab[9]  = '{0, 3'd6, 8'd6, 1'b0, 7'b0010010};
        tab[10] = '{0, 3'd0, 8'd7, 1'b0, 7'b0010010};
        tab[11] = '{0, 3'd1, 8'd8, 1'b0, 7'b0000010};
        bus.value = 3'd0;
        model_reset();
        #0.5;
        check_reset_outputs("reset_hold");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) run_vec(i);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] eds;
            tick(3'd5);
            eds = ~(4'b0001 << ((i / 4 + 1) % 4));
            chk("scan_step", 32'(bus.digitselect), 32'(eds));
            if (i >= 4 && i < 12) chk("blank_digit", 32'(bus.segments), 32'(7'b1111111));
        end
        for (int i = 3; i < 12; i++) run_vec(i);
        for (int i = 0; i < 16; i++) begin
            tick(3'd1);
            chk("hist_seq", 32'(bus.segments), 32'(seg_tab[h4[exp_scan()]]));
        end
        tick(3'd7);
        chk("err_set", 32'(bus.error), 1);
        for (int i = 0; i < 16; i++) begin
            tick(3'd2);
            chk("err_sticky", 32'(bus.error), 1);
            if (exp_scan() == 1) chk("dash_digit", 32'(bus.segments), 32'(7'b0111111));
        end
        for (int i = 0; i < 300; i++) tick((i % 2 == 0) ? 3'd1 : 3'd2);
        chk("cnt_saturate", 32'(bus.change_count), 255);
        pulse_reset();
        last = 3'd0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            if ($urandom_range(0, 2) == 0) last = 3'($urandom_range(0, 7));
            tick(last);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
